// File: rtl/uart_tx_mmio.sv
// Memory-mapped UART transmitter: CPU writes fill a TX FIFO that is drained as 8N1 frames on tx.
// Optional even-parity bit between data and stop when UART_TX_PARITY_EN is defined.
module uart_tx_mmio #(
    parameter int CLKS_PER_BIT = 200,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic        clock,
    input  logic        rst_n,
    input  logic        uartcs,
    input  logic        uartwrite,
    input  logic        uartread,
    input  logic [1:0]  uartaddr,
    input  logic [15:0] uartwdata,
    output logic [15:0] uartrdata,
    output logic        tx,
    output logic        busy
);

    localparam int BW   = $clog2(CLKS_PER_BIT);
    localparam int PW   = $clog2(FIFO_DEPTH);
    localparam int CNTW = PW + 1;
    localparam logic [BW-1:0]   BAUD_LAST = BW'(CLKS_PER_BIT - 1);
    localparam logic [CNTW-1:0] DEPTH_C   = CNTW'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    function automatic logic even_parity(input logic [7:0] d);
        return ^d;
    endfunction

    logic [7:0]      r_mem [FIFO_DEPTH];
    logic [PW-1:0]   r_wr_ptr;
    logic [PW-1:0]   r_rd_ptr;
    logic [CNTW-1:0] r_count;
    logic            r_ovf;
    state_t          r_state;
    state_t          w_state_next;
    logic [BW-1:0]   r_baud;
    logic [BW-1:0]   w_baud_next;
    logic [2:0]      r_bit;
    logic [2:0]      w_bit_next;
    logic [7:0]      r_shift;
    logic [7:0]      w_shift_next;
    logic            r_tx;
    logic            w_tx_next;
    logic            w_pop;
    logic            w_push_req;
    logic            w_push;
    logic            w_full;
    logic            w_empty;
    logic            w_stat_rd;
    logic            w_baud_done;
    logic [7:0]      w_head;
    logic [7:0]      w_cnt8;
    logic [15:0]     w_status;
    logic            w_unused_wdata;
`ifdef UART_TX_PARITY_EN
    logic            r_par;
    logic            w_par_next;
`endif

    assign w_full         = (r_count == DEPTH_C);
    assign w_empty        = (r_count == {CNTW{1'b0}});
    assign w_push_req     = uartcs & uartwrite & (uartaddr == 2'b00);
    assign w_push         = w_push_req & ~w_full;
    assign w_stat_rd      = uartcs & uartread & (uartaddr == 2'b10);
    assign w_baud_done    = (r_baud == BAUD_LAST);
    assign w_head         = r_mem[r_rd_ptr];
    assign w_cnt8         = 8'(r_count);
    assign w_unused_wdata = &{1'b0, uartwdata[15:8]};
    assign tx             = r_tx;
    assign busy           = (r_state != S_IDLE) | ~w_empty;

`ifdef UART_TX_PARITY_EN
    assign w_status = {1'b1, w_cnt8[6:0], 4'b0000, r_ovf, busy, w_empty, w_full};
`else
    assign w_status = {w_cnt8, 4'b0000, r_ovf, busy, w_empty, w_full};
`endif

    // Read mux: only a selected status read drives the bus.
    always_comb begin
        uartrdata = 16'h0000;
        if (w_stat_rd) begin
            uartrdata = w_status;
        end else begin
            uartrdata = 16'h0000;
        end
    end

    // FIFO storage; contents need no reset because count gates every read.
    always_ff @(posedge clock) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= uartwdata[7:0];
        end
    end

    // FIFO pointers, occupancy and sticky overflow flag.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= {PW{1'b0}};
            r_rd_ptr <= {PW{1'b0}};
            r_count  <= {CNTW{1'b0}};
            r_ovf    <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNTW'(1);
                2'b01:   r_count <= r_count - CNTW'(1);
                default: r_count <= r_count;
            endcase
            // A drop in the same cycle as the status read must stay visible.
            if (w_push_req && w_full) begin
                r_ovf <= 1'b1;
            end else if (w_stat_rd) begin
                r_ovf <= 1'b0;
            end
        end
    end

    // Serializer state and datapath registers; tx is registered for a glitch-free line.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_baud  <= {BW{1'b0}};
            r_bit   <= 3'd0;
            r_shift <= 8'h00;
            r_tx    <= 1'b1;
`ifdef UART_TX_PARITY_EN
            r_par   <= 1'b0;
`endif
        end else begin
            r_state <= w_state_next;
            r_baud  <= w_baud_next;
            r_bit   <= w_bit_next;
            r_shift <= w_shift_next;
            r_tx    <= w_tx_next;
`ifdef UART_TX_PARITY_EN
            r_par   <= w_par_next;
`endif
        end
    end

    // Next-state logic; tx is derived from the state being entered so it changes on that edge.
    always_comb begin
        w_state_next = r_state;
        w_baud_next  = r_baud;
        w_bit_next   = r_bit;
        w_shift_next = r_shift;
        w_pop        = 1'b0;
        w_tx_next    = 1'b1;
`ifdef UART_TX_PARITY_EN
        w_par_next   = r_par;
`endif
        case (r_state)
            S_IDLE: begin
                w_baud_next = {BW{1'b0}};
                w_bit_next  = 3'd0;
                if (!w_empty) begin
                    w_pop        = 1'b1;
                    w_shift_next = w_head;
                    w_state_next = S_START;
`ifdef UART_TX_PARITY_EN
                    w_par_next   = even_parity(w_head);
`endif
                end else begin
                    w_state_next = S_IDLE;
                end
            end
            S_START: begin
                if (w_baud_done) begin
                    w_baud_next  = {BW{1'b0}};
                    w_bit_next   = 3'd0;
                    w_state_next = S_DATA;
                end else begin
                    w_baud_next = r_baud + BW'(1);
                end
            end
            S_DATA: begin
                if (w_baud_done) begin
                    w_baud_next = {BW{1'b0}};
                    if (r_bit == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        w_state_next = S_PARITY;
`else
                        w_state_next = S_STOP;
`endif
                    end else begin
                        w_bit_next   = r_bit + 3'd1;
                        w_shift_next = {1'b0, r_shift[7:1]};
                    end
                end else begin
                    w_baud_next = r_baud + BW'(1);
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                if (w_baud_done) begin
                    w_baud_next  = {BW{1'b0}};
                    w_state_next = S_STOP;
                end else begin
                    w_baud_next = r_baud + BW'(1);
                end
            end
`endif
            S_STOP: begin
                if (w_baud_done) begin
                    w_baud_next  = {BW{1'b0}};
                    w_state_next = S_IDLE;
                end else begin
                    w_baud_next = r_baud + BW'(1);
                end
            end
            default: begin
                w_state_next = S_IDLE;
                w_baud_next  = {BW{1'b0}};
            end
        endcase

        case (w_state_next)
            S_START: w_tx_next = 1'b0;
            S_DATA:  w_tx_next = w_shift_next[0];
`ifdef UART_TX_PARITY_EN
            S_PARITY: w_tx_next = w_par_next;
`endif
            default: w_tx_next = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_uart_tx_mmio.sv
// Randomized scoreboard bench for uart_tx_mmio: a cycle-timed FIFO model predicts frames,
// a line monitor decodes tx and compares against the expected-frame queue.
module tb_uart_tx_mmio;
    localparam int CPB   = 4;
    localparam int DEPTH = 4;
`ifdef UART_TX_PARITY_EN
    localparam int NSEG = 11;
    localparam bit PAR  = 1'b1;
`else
    localparam int NSEG = 10;
    localparam bit PAR  = 1'b0;
`endif
    localparam int F = NSEG * CPB;
    localparam int P = F + 1;

    logic        clock = 1'b0;
    logic        rst_n;
    logic        uartcs, uartwrite, uartread;
    logic [1:0]  uartaddr;
    logic [15:0] uartwdata;
    logic [15:0] uartrdata;
    logic        tx, busy;

    uart_tx_mmio #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
        .clock(clock), .rst_n(rst_n), .uartcs(uartcs), .uartwrite(uartwrite),
        .uartread(uartread), .uartaddr(uartaddr), .uartwdata(uartwdata),
        .uartrdata(uartrdata), .tx(tx), .busy(busy)
    );

    always #5 clock = ~clock;

    typedef struct { logic [7:0] b; int e; } exp_t;
    exp_t        sb_q[$];
    logic [7:0]  m_q[$];
    int          m_edge = 0;
    int          m_last_pop = 0;
    int          m_next_pop = 0;
    bit          m_have_pop = 1'b0;
    bit          m_ovf = 1'b0;
    bit          mon_act = 1'b0;
    logic [15:0] last_rd;
    int          checks = 0;
    int          failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, req, $time);
        end
    endtask

    function automatic logic m_busy();
        return (m_q.size() != 0) || (m_have_pop && (m_edge < m_last_pop + P - 1));
    endfunction

    function automatic logic [15:0] m_status();
        int          c;
        logic [7:0]  c8;
        logic [15:0] s;
        c  = m_q.size();
        c8 = 8'(c);
        s  = {c8, 4'b0000, m_ovf, m_busy(), (c == 0), (c == DEPTH)};
        if (PAR) s[15] = 1'b1;
        return s;
    endfunction

    task automatic model_reset();
        m_q.delete();
        sb_q.delete();
        m_ovf      = 1'b0;
        m_have_pop = 1'b0;
        m_next_pop = 0;
    endtask

    task automatic idle_in();
        uartcs = 1'b0; uartwrite = 1'b0; uartread = 1'b0;
        uartaddr = 2'b00; uartwdata = 16'h0000;
    endtask

    // One clock: check the read bus, advance the model across the edge, check busy.
    task automatic tick();
        logic       push_req, rd_st, rst_cap;
        logic [7:0] d;
        int         c;
        exp_t       ex;
        #1;
        last_rd = uartrdata;
        check("rdata", uartrdata, (uartcs && uartread && uartaddr == 2'b10) ? m_status() : 16'h0000);
        push_req = uartcs && uartwrite && (uartaddr == 2'b00);
        rd_st    = uartcs && uartread && (uartaddr == 2'b10);
        d        = uartwdata[7:0];
        rst_cap  = rst_n;
        @(posedge clock);
        m_edge++;
        if (!rst_cap) begin
            model_reset();
        end else begin
            c = m_q.size();
            if (c > 0 && m_edge >= m_next_pop) begin
                ex.b = m_q.pop_front();
                ex.e = m_edge;
                sb_q.push_back(ex);
                m_last_pop = m_edge;
                m_have_pop = 1'b1;
                m_next_pop = m_edge + P;
            end
            if (push_req && c == DEPTH) m_ovf = 1'b1;
            else if (rd_st) m_ovf = 1'b0;
            if (push_req && c != DEPTH) m_q.push_back(d);
        end
        #1;
        check("busy", busy, m_busy());
    endtask

    task automatic wr(input logic [1:0] a, input logic [7:0] d);
        uartcs = 1'b1; uartwrite = 1'b1; uartaddr = a; uartwdata = {8'hEE, d};
        tick();
        idle_in();
    endtask

    task automatic rd(input logic [1:0] a, input logic cs);
        uartcs = cs; uartread = 1'b1; uartaddr = a;
        tick();
        idle_in();
    endtask

    task automatic drain(input bit do_reads);
        int i;
        for (i = 0; i < 3000; i++) begin
            if (!m_busy() && m_q.size() == 0) break;
            if (do_reads) rd(2'b10, 1'b1);
            else tick();
        end
        check("drain_timeout", (i < 3000), 1);
        tick(); tick();
        check("drain_sb_empty", sb_q.size(), 0);
        check("drain_monitor_idle", mon_act, 0);
    endtask

    // Line monitor: decodes each frame sample by sample against the expected-frame queue.
    initial begin
        exp_t       cur;
        int         k, seg, bad;
        logic [7:0] rx;
        logic       exp_bit;
        forever begin
            @(negedge clock);
            if (!rst_n) begin
                mon_act = 1'b0;
            end else begin
                if (!mon_act && tx === 1'b0) begin
                    check("frame_expected", (sb_q.size() != 0), 1);
                    if (sb_q.size() != 0) begin
                        cur = sb_q.pop_front();
                        check("start_edge", m_edge, cur.e);
                        mon_act = 1'b1; k = 0; bad = 0; rx = 8'h00;
                    end
                end
                if (mon_act) begin
                    seg = k / CPB;
                    if (seg == 0) exp_bit = 1'b0;
                    else if (seg <= 8) exp_bit = cur.b[seg-1];
                    else if (PAR && seg == 9) exp_bit = ^cur.b;
                    else exp_bit = 1'b1;
                    if (tx !== exp_bit) bad++;
                    if (seg >= 1 && seg <= 8 && (k % CPB) == CPB / 2) rx[seg-1] = tx;
                    k++;
                    if (k == F) begin
                        check("frame_data", rx, cur.b);
                        check("frame_shape_errs", bad, 0);
                        mon_act = 1'b0;
                    end
                end
            end
        end
    end

    initial begin
        logic [15:0] st_reset;
        st_reset = PAR ? 16'h8002 : 16'h0002;
        idle_in();
        rst_n = 1'b0;
        model_reset();
        tick(); tick(); tick();
        check("reset_tx", tx, 1);
        rst_n = 1'b1;
        tick();
        rd(2'b10, 1'b1);
        check("reset_status", last_rd, st_reset);

        wr(2'b00, 8'hA5);
        drain(1'b0);

        wr(2'b00, 8'h01); wr(2'b00, 8'h02); wr(2'b00, 8'h03);
        drain(1'b1);

        for (int i = 0; i < 6; i++) wr(2'b00, 8'(8'h30 + i));
        rd(2'b10, 1'b1);
        check("ovf_set", last_rd[3], 1);
        rd(2'b10, 1'b1);
        check("ovf_cleared", last_rd[3], 0);
        drain(1'b0);

        wr(2'b00, 8'h07);
        rd(2'b00, 1'b1);
        check("data_read_zero", last_rd, 16'h0000);
        rd(2'b10, 1'b0);
        check("unselected_read_zero", last_rd, 16'h0000);
        wr(2'b10, 8'h55); wr(2'b01, 8'h66); wr(2'b11, 8'h77);
        rd(2'b10, 1'b1);
        drain(1'b0);

        for (int i = 0; i < 1500; i++) begin
            uartcs    = ($urandom_range(0, 9) != 0);
            uartwrite = ($urandom_range(0, 99) < 8);
            uartread  = ($urandom_range(0, 3) == 0);
            uartaddr  = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 1) == 1) uartaddr = 2'b00;
            uartwdata = 16'($urandom);
            tick();
        end
        idle_in();
        drain(1'b0);

        wr(2'b00, 8'($urandom));
        wr(2'b00, 8'($urandom));
        for (int i = 0; i < 15; i++) tick();
        rst_n = 1'b0;
        model_reset();
        #1;
        check("midframe_reset_tx", tx, 1);
        check("midframe_reset_busy", busy, 0);
        check("midframe_reset_rdata", uartrdata, 16'h0000);
        tick(); tick();
        rst_n = 1'b1;
        rd(2'b10, 1'b1);
        check("post_reset_status", last_rd, st_reset);
        wr(2'b00, 8'h3C);
        drain(1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
